// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX->MEM pipeline register with a 2-entry skid buffer that
//                absorbs MEM backpressure, plus signed-overflow detection.
//                Optional feature macro: OVF_TRAP_EN (overflowing ops retire
//                with their side effects suppressed, raise an Ov exception
//                and park the stage in TRAP until flush or reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_overflow,
   input  logic             ovf_check,
   input  logic [WIDTH-1:0] store_data,
   input  logic [RADDR-1:0] wb_reg,
   input  logic             wb_en,
   input  logic             mem_rd,
   input  logic             mem_wr,
   input  logic [WIDTH-1:0] pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] out_store_data,
   output logic [WIDTH-1:0] out_pc,
   output logic [RADDR-1:0] out_wb_reg,
   output logic             out_wb_en,
   output logic             out_mem_rd,
   output logic             out_mem_wr,
   output logic             exc_valid,
   output logic [WIDTH-1:0] exc_epc,
   output logic [4:0]       exc_cause
);

   // Occupancy FSM; TRAP only exists when the trap feature is built in.
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;
`ifdef OVF_TRAP_EN
   localparam logic [1:0] S_TRAP   = 2'd3;
   localparam logic [4:0] CAUSE_OV = 5'd12;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [WIDTH-1:0] store_data;
      logic [WIDTH-1:0] pc;
      logic [RADDR-1:0] wb_reg;
      logic             wb_en;
      logic             mem_rd;
      logic             mem_wr;
      logic             ovf;
   } entry_t;

   logic [1:0] state;
   logic [1:0] state_nxt;
   entry_t     head;       // oldest entry, drives out_*
   entry_t     skid;       // second entry, only meaningful in S_TWO
   entry_t     in_entry;
   logic       push;
   logic       pop;
   logic       ovf_in;

   assign push   = in_valid & in_ready;
   assign pop    = out_valid & out_ready;
   assign ovf_in = ovf_check & alu_overflow;

`ifdef OVF_TRAP_EN
   logic trap_retire;
   assign trap_retire = pop & head.ovf;
`else
   logic unused_ovf;
   assign unused_ovf = head.ovf;
`endif

   // Build the entry to be captured; trapping ops lose their side effects here.
   always_comb begin
      in_entry.result     = alu_result;
      in_entry.store_data = store_data;
      in_entry.pc         = pc;
      in_entry.wb_reg     = wb_reg;
      in_entry.wb_en      = wb_en;
      in_entry.mem_rd     = mem_rd;
      in_entry.mem_wr     = mem_wr;
      in_entry.ovf        = ovf_in;
`ifdef OVF_TRAP_EN
      if (ovf_in) begin
         in_entry.wb_en  = 1'b0;
         in_entry.mem_rd = 1'b0;
         in_entry.mem_wr = 1'b0;
      end
`endif
   end

   // State register plus registered in_ready derived from the next occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != S_TWO);
      end
   end

   // Next-state logic: flush dominates, then trap retire, then occupancy.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_EMPTY;
`ifdef OVF_TRAP_EN
      end else if (trap_retire) begin
         state_nxt = S_TRAP;
`endif
      end else begin
         case (state)
            S_EMPTY: if (push) state_nxt = S_ONE;
            S_ONE: begin
               if (push && !pop)      state_nxt = S_TWO;
               else if (pop && !push) state_nxt = S_EMPTY;
            end
            S_TWO:   if (pop && !push) state_nxt = S_ONE;
            default: state_nxt = state;
         endcase
      end
   end

   // Output decode: head is visible only while the buffer holds something.
   always_comb begin
      out_valid = (state == S_ONE) || (state == S_TWO);
   end

   // Entry storage: head refills from skid or input; skid fills when ONE stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head <= '0;
         skid <= '0;
      end else begin
         if (pop && (state == S_TWO))
            head <= skid;
         else if (push && ((state == S_EMPTY) || ((state == S_ONE) && pop)))
            head <= in_entry;
         if (push && (state == S_ONE) && !pop)
            skid <= in_entry;
      end
   end

   assign out_result     = head.result;
   assign out_store_data = head.store_data;
   assign out_pc         = head.pc;
   assign out_wb_reg     = head.wb_reg;
   assign out_wb_en      = head.wb_en;
   assign out_mem_rd     = head.mem_rd;
   assign out_mem_wr     = head.mem_wr;

`ifdef OVF_TRAP_EN
   // Exception pulse one cycle after an overflowing op retires; epc/cause persist.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exc_valid <= 1'b0;
         exc_epc   <= '0;
         exc_cause <= '0;
      end else begin
         exc_valid <= 1'b0;
         if (trap_retire && !flush) begin
            exc_valid <= 1'b1;
            exc_epc   <= head.pc;
            exc_cause <= CAUSE_OV;
         end
      end
   end
`else
   assign exc_valid = 1'b0;
   assign exc_epc   = '0;
   assign exc_cause = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage: directed scenarios
//                followed by random traffic, compared against a queue-based
//                reference model of the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

`ifdef OVF_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [31:0] alu_result, store_data, pc;
   logic        alu_overflow, ovf_check;
   logic [4:0]  wb_reg;
   logic        wb_en, mem_rd, mem_wr, flush;
   logic        out_valid, out_ready;
   logic [31:0] out_result, out_store_data, out_pc;
   logic [4:0]  out_wb_reg;
   logic        out_wb_en, out_mem_rd, out_mem_wr;
   logic        exc_valid;
   logic [31:0] exc_epc;
   logic [4:0]  exc_cause;

   ex_mem_stage #(.WIDTH(32), .RADDR(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .alu_overflow(alu_overflow), .ovf_check(ovf_check),
      .store_data(store_data), .wb_reg(wb_reg), .wb_en(wb_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .pc(pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data), .out_pc(out_pc),
      .out_wb_reg(out_wb_reg), .out_wb_en(out_wb_en), .out_mem_rd(out_mem_rd),
      .out_mem_wr(out_mem_wr),
      .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_cause(exc_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      logic [31:0] sd;
      logic [31:0] pc;
      logic [4:0]  rg;
      logic        wb, rd, wr, ovf;
   } ent_t;

   ent_t        q[$];
   bit          m_trap;
   bit          m_in_ready;
   bit          m_exc;
   logic [31:0] m_epc;
   logic [4:0]  m_cause;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_trap = 1'b0; m_in_ready = 1'b1; m_exc = 1'b0;
      m_epc = '0; m_cause = '0;
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit   do_push, do_pop, trapped;
      ent_t cur, h;
      cur.result = alu_result; cur.sd = store_data; cur.pc = pc; cur.rg = wb_reg;
      cur.wb = wb_en; cur.rd = mem_rd; cur.wr = mem_wr;
      cur.ovf = ovf_check & alu_overflow;
      do_push = in_valid && m_in_ready;
      do_pop  = (q.size() > 0) && !m_trap && out_ready;
      trapped = 1'b0;
      m_exc   = 1'b0;
      if (flush) begin
         q.delete();
         m_trap = 1'b0;
      end else begin
         if (do_pop) begin
            h = q.pop_front();
            if (TRAP_EN && h.ovf) begin
               trapped = 1'b1; m_trap = 1'b1; m_exc = 1'b1;
               m_epc = h.pc; m_cause = 5'd12;
               q.delete();
            end
         end
         if (do_push && !m_trap && !trapped) q.push_back(cur);
      end
      m_in_ready = m_trap || (q.size() < 2);
   endtask

   task automatic check_outputs();
      bit   vis;
      bit   suppress;
      vis = (q.size() > 0) && !m_trap;
      chk("out_valid", out_valid, vis);
      chk("in_ready", in_ready, m_in_ready);
      chk("exc_valid", exc_valid, m_exc);
      chk("exc_epc", exc_epc, m_epc);
      chk("exc_cause", exc_cause, m_cause);
      if (vis) begin
         suppress = TRAP_EN && q[0].ovf;
         chk("out_result", out_result, q[0].result);
         chk("out_store_data", out_store_data, q[0].sd);
         chk("out_pc", out_pc, q[0].pc);
         chk("out_wb_reg", out_wb_reg, q[0].rg);
         chk("out_wb_en", out_wb_en, suppress ? 1'b0 : q[0].wb);
         chk("out_mem_rd", out_mem_rd, suppress ? 1'b0 : q[0].rd);
         chk("out_mem_wr", out_mem_wr, suppress ? 1'b0 : q[0].wr);
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic set_op(input bit v, input logic [31:0] res, input logic [31:0] p,
                         input bit oc, input bit ov);
      in_valid = v; alu_result = res; pc = p; ovf_check = oc; alu_overflow = ov;
      store_data = $urandom; wb_reg = 5'($urandom);
      wb_en = 1'($urandom); mem_rd = 1'($urandom); mem_wr = 1'($urandom);
   endtask

   task automatic check_reset_values();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_exc_valid", exc_valid, 1'b0);
      chk("rst_exc_epc", exc_epc, 32'h0);
      chk("rst_exc_cause", exc_cause, 5'h0);
      chk("rst_out_result", out_result, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_sideband", {out_wb_reg, out_wb_en, out_mem_rd, out_mem_wr}, 8'h0);
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_reset_values();
      reset_n = 1'b1;

      // Streaming with a free MEM stage: one-cycle latency, back-to-back.
      out_ready = 1'b1;
      set_op(1'b1, 32'h1, 32'h100, 1'b0, 1'b0); cycle();
      chk("stream_first", out_result, 32'h1);
      set_op(1'b1, 32'h2, 32'h104, 1'b0, 1'b0); cycle();
      chk("stream_second", out_result, 32'h2);
      set_op(1'b1, 32'h3, 32'h108, 1'b0, 1'b0); cycle();
      chk("stream_third", out_result, 32'h3);
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();

      // Backpressure: fill both slots, head stays stable, then drain in order.
      out_ready = 1'b0;
      set_op(1'b1, 32'hA, 32'h200, 1'b0, 1'b0); cycle();
      set_op(1'b1, 32'hB, 32'h204, 1'b0, 1'b0); cycle();
      chk("bp_in_ready_low", in_ready, 1'b0);
      set_op(1'b1, 32'hC, 32'h208, 1'b0, 1'b0); cycle();
      chk("bp_head_hold", out_result, 32'hA);
      cycle();
      out_ready = 1'b1;
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
      chk("bp_drain_b", out_result, 32'hB);
      cycle();
      cycle();

      // Flush with both slots full and a new op offered: everything squashed.
      out_ready = 1'b0;
      set_op(1'b1, 32'h11, 32'h300, 1'b0, 1'b0); cycle();
      set_op(1'b1, 32'h12, 32'h304, 1'b0, 1'b0); cycle();
      flush = 1'b1;
      set_op(1'b1, 32'h13, 32'h308, 1'b0, 1'b0); cycle();
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      flush = 1'b0;
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();

      // Asynchronous reset mid-stream with two entries held.
      set_op(1'b1, 32'h21, 32'h400, 1'b0, 1'b0); cycle();
      set_op(1'b1, 32'h22, 32'h404, 1'b0, 1'b0); cycle();
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check_reset_values();
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Signed overflow: 0x7fffffff + 1 wraps to 0x80000000.
      out_ready = 1'b0;
      set_op(1'b1, 32'h8000_0000, 32'h400, 1'b1, 1'b1);
      wb_en = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
      cycle();
      chk("ovf_wrapped_result", out_result, 32'h8000_0000);
      chk("ovf_wb_en", out_wb_en, TRAP_EN ? 1'b0 : 1'b1);
      set_op(1'b1, 32'h55, 32'h404, 1'b0, 1'b0); cycle();
      out_ready = 1'b1;
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
      chk("ovf_exc_pulse", exc_valid, TRAP_EN);
      chk("ovf_exc_epc", exc_epc, TRAP_EN ? 32'h400 : 32'h0);
      set_op(1'b1, 32'h66, 32'h408, 1'b0, 1'b0); cycle();
      chk("ovf_exc_single", exc_valid, 1'b0);
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();
      flush = 1'b1; cycle();
      flush = 1'b0;
      set_op(1'b1, 32'h77, 32'h40C, 1'b0, 1'b0); cycle();
      chk("post_flush_op", out_result, 32'h77);
      set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); cycle();

      // Random traffic with backpressure, overflows and occasional flushes.
      for (int i = 0; i < 600; i++) begin
         set_op(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
